// File: rtl/rmt_stage_pkg.sv
// Shared constants for the RMT stage wrapper: PHV field geometry and the
// mode-switch state encoding used by stage_flow_ctrl.
// Ports: none (package).
package rmt_stage_pkg;

  // PHV container geometry: 8x48b, 8x32b, 8x16b, 5x20b metadata, 256b user area.
  localparam int PHV_B6_NUM  = 8;
  localparam int PHV_B6_W    = 48;
  localparam int PHV_B4_NUM  = 8;
  localparam int PHV_B4_W    = 32;
  localparam int PHV_B2_NUM  = 8;
  localparam int PHV_B2_W    = 16;
  localparam int PHV_MD_NUM  = 5;
  localparam int PHV_MD_W    = 20;
  localparam int PHV_USR_W   = 256;

  function automatic int phv_len_calc();
    return PHV_B6_NUM * PHV_B6_W + PHV_B4_NUM * PHV_B4_W + PHV_B2_NUM * PHV_B2_W
         + PHV_MD_NUM * PHV_MD_W + PHV_USR_W;
  endfunction

  localparam int PHV_LEN_DEF = phv_len_calc();

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BYPASS = 2'd1,
    ST_DRAIN  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/stage_phv_fifo.sv
// First-word-fall-through sync FIFO holding PHVs leaving the stage.
// Latency: write at t is visible on rd_vld_o/rd_dat_o at t+1.
// Backpressure: rd_rdy_i pops the head; writes to a full FIFO are discarded
// (the caller's credit scheme keeps that from happening).
// Ports: clk_i, rst_ni, wr_vld_i/wr_dat_i, rd_vld_o/rd_dat_o/rd_rdy_i, count_o.
module stage_phv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_vld_i,
  input  logic [WIDTH-1:0]           wr_dat_i,
  output logic                       rd_vld_o,
  output logic [WIDTH-1:0]           rd_dat_o,
  input  logic                       rd_rdy_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign do_wr = wr_vld_i && (count_q != DEPTH_V);
  assign do_rd = rd_rdy_i && (count_q != '0);

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

endmodule

// File: rtl/stage_flow_ctrl.sv
// Flow-control shell around one RMT stage datapath with a credit-checked
// output FIFO and a run/bypass mode switch that waits for the datapath to drain.
// Latency: issue to datapath at accept+1; bypass output valid at accept+2.
// Backpressure: phv_in_ready drops when FIFO + in-flight + issue slot reach
// FIFO_DEPTH, and while draining for a mode change.
// Ports: axis_clk/aresetn; phv_in* upstream; phv_out* downstream; pipe_* to and
// from the stage datapath; cfg_* mode requests; bypass_active, stg_ready,
// phv_cnt, err status.
module stage_flow_ctrl
  import rmt_stage_pkg::*;
#(
  parameter int PHV_LEN    = PHV_LEN_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_in_valid,
  output logic               phv_in_ready,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
  input  logic               phv_out_ready,
  output logic [PHV_LEN-1:0] pipe_phv_out,
  output logic               pipe_phv_out_valid,
  input  logic [PHV_LEN-1:0] pipe_phv_in,
  input  logic               pipe_phv_in_valid,
  input  logic               cfg_bypass,
  input  logic               cfg_bypass_valid,
  output logic               cfg_ack,
  output logic               bypass_active,
  output logic               stg_ready,
  output logic [CNT_W-1:0]   phv_cnt,
  output logic               err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  stage_state_e       state_q;
  logic               target_q;
  logic               bypass_q;
  logic               ack_q;

  logic               alive_q;
  logic               iss_vld_q;
  logic [PHV_LEN-1:0] iss_dat_q, iss_dat_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [CW-1:0]      fifo_cnt;
  logic [CW:0]        occ;
  logic               accept, issue, ret_ok, ret_bad;
  logic               fifo_wr, fifo_rd;
  logic [PHV_LEN-1:0] fifo_wdat;

  // Every PHV accepted but not yet read out holds one credit, wherever it sits.
  assign occ = {1'b0, fifo_cnt} + {1'b0, inflight_q} + {{CW{1'b0}}, iss_vld_q};

  // alive_q keeps ready low while reset is held and for the release edge.
  assign phv_in_ready = alive_q && (state_q != ST_DRAIN) && (occ < DEPTH_V);
  assign accept       = phv_in_valid && phv_in_ready;

  assign issue   = iss_vld_q && !bypass_q;
  assign ret_ok  = pipe_phv_in_valid && (inflight_q != '0);
  assign ret_bad = pipe_phv_in_valid && (inflight_q == '0);

  // The two FIFO sources are exclusive: bypass only starts with inflight==0,
  // and any return seen then is an error and is dropped.
  assign fifo_wr   = ret_ok || (iss_vld_q && bypass_q);
  assign fifo_wdat = ret_ok ? pipe_phv_in : iss_dat_q;
  assign fifo_rd   = phv_out_valid && phv_out_ready;

  always_comb begin
    iss_dat_d  = iss_dat_q;
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    err_d      = err_q || ret_bad;
    if (accept) begin
      iss_dat_d = phv_in;
      cnt_d     = cnt_q + CNT_W'(1);
    end
    case ({issue, ret_ok})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      alive_q    <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_dat_q  <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      alive_q    <= 1'b1;
      iss_vld_q  <= accept;
      iss_dat_q  <= iss_dat_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Mode FSM. A differing request parks in DRAIN until nothing accepted is
  // still upstream of the FIFO; FIFO order alone then keeps outputs in order.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_RUN;
      target_q <= 1'b0;
      bypass_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_RUN, ST_BYPASS: begin
          if (cfg_bypass_valid) begin
            if (cfg_bypass == bypass_q) begin
              ack_q <= 1'b1;
            end else begin
              target_q <= cfg_bypass;
              state_q  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Requests arriving here are dropped on purpose: no retarget, no ack.
          if ((inflight_q == '0) && !iss_vld_q) begin
            state_q  <= target_q ? ST_BYPASS : ST_RUN;
            bypass_q <= target_q;
            ack_q    <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  stage_phv_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (axis_clk),
    .rst_ni   (aresetn),
    .wr_vld_i (fifo_wr),
    .wr_dat_i (fifo_wdat),
    .rd_vld_o (phv_out_valid),
    .rd_dat_o (phv_out),
    .rd_rdy_i (phv_out_ready),
    .count_o  (fifo_cnt)
  );

  assign pipe_phv_out       = iss_dat_q;
  assign pipe_phv_out_valid = issue;
  assign cfg_ack            = ack_q;
  assign bypass_active      = bypass_q;
  assign stg_ready          = (state_q != ST_DRAIN) && (inflight_q == '0) &&
                              !iss_vld_q && (fifo_cnt == '0);
  assign phv_cnt            = cnt_q;
  assign err                = err_q;

endmodule
